// File: rtl/ultrasonic_ping_scheduler_if.sv
// Sensor-side and paddle-side signals of the two-player ultrasonic ping scheduler.
interface ultrasonic_ping_scheduler_if #(
  parameter int DIST_W = 9
);
  logic              enable;
  logic [1:0]        echo_in;
  logic [1:0]        trig_out;
  logic [DIST_W-1:0] dist_p1;
  logic [DIST_W-1:0] dist_p2;
  logic              valid_p1;
  logic              valid_p2;
  logic              timeout_p1;
  logic              timeout_p2;
  logic              busy;
  logic              sel;

  modport master (
    input  enable, echo_in,
    output trig_out, dist_p1, dist_p2, valid_p1, valid_p2,
    output timeout_p1, timeout_p2, busy, sel
  );

  modport slave (
    output enable, echo_in,
    input  trig_out, dist_p1, dist_p2, valid_p1, valid_p2,
    input  timeout_p1, timeout_p2, busy, sel
  );
endinterface

// File: rtl/ultrasonic_ping_scheduler.sv
// Round-robin scheduler for two HC-SR04 sensors: trigger, echo timing, cm conversion.
// Optional macro TIMEOUT_HOLD_EN: a timed-out ping keeps the previous distance.
module ultrasonic_ping_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2915,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int HOLDOFF_CYCLES = 3000000,
  parameter int DIST_W         = 9
) (
  input logic                        CLOCK_50,
  input logic                        resetn,
  ultrasonic_ping_scheduler_if.master bus
);
  localparam int PHASE_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [PHASE_W-1:0] TRIG_LAST = PHASE_W'(TRIG_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST = PHASE_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0]  DIST_MAX  = '1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t              state_reg, state_next;
  logic                sel_reg, sel_next;
  logic [PHASE_W-1:0]  phase_reg, phase_next;
  logic [TMO_W-1:0]    tmo_reg, tmo_next;
  logic [SUB_W-1:0]    sub_reg, sub_next;
  logic [DIST_W-1:0]   cm_reg, cm_next;

  logic                publish, pub_timeout;
  logic [DIST_W-1:0]   pub_dist;
  logic                echo_now, echo_prev, echo_rise, echo_fall, tmo_hit;

  logic [1:0]          echo_sync_w, echo_prev_w, valid_w, timeout_w;
  logic [DIST_W-1:0]   dist_w [2];

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      phase_reg <= '0;
      tmo_reg   <= '0;
      sub_reg   <= '0;
      cm_reg    <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      phase_reg <= phase_next;
      tmo_reg   <= tmo_next;
      sub_reg   <= sub_next;
      cm_reg    <= cm_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    phase_next  = phase_reg;
    tmo_next    = tmo_reg;
    sub_next    = sub_reg;
    cm_next     = cm_reg;
    publish     = 1'b0;
    pub_timeout = 1'b0;
    pub_dist    = cm_reg;

    echo_now  = echo_sync_w[sel_reg];
    echo_prev = echo_prev_w[sel_reg];
    echo_rise = echo_now & ~echo_prev;
    echo_fall = ~echo_now & echo_prev;
    tmo_hit   = (tmo_reg == TMO_LAST);

    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          state_next = TRIG;
          phase_next = '0;
          tmo_next   = '0;
          sub_next   = '0;
          cm_next    = '0;
        end
      end
      TRIG: begin
        if (phase_reg == TRIG_LAST) begin
          state_next = WAIT_RISE;
          phase_next = '0;
          tmo_next   = '0;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      WAIT_RISE: begin
        if (tmo_hit) begin
          publish     = 1'b1;
          pub_timeout = 1'b1;
          state_next  = HOLDOFF;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
          if (echo_rise) begin
            state_next = MEASURE;
            sub_next   = '0;
            cm_next    = '0;
          end
        end
      end
      MEASURE: begin
        // Count on the delayed copy so the fall cycle's clock is included in the result.
        if (echo_prev) begin
          if (sub_reg == SUB_LAST) begin
            sub_next = '0;
            if (cm_reg != DIST_MAX) cm_next = cm_reg + DIST_W'(1);
          end else begin
            sub_next = sub_reg + SUB_W'(1);
          end
        end
        if (echo_fall) begin
          publish    = 1'b1;
          pub_dist   = cm_next;
          state_next = HOLDOFF;
        end else if (tmo_hit) begin
          publish     = 1'b1;
          pub_timeout = 1'b1;
          state_next  = HOLDOFF;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      HOLDOFF: begin
        if (phase_reg == HOLD_LAST) begin
          sel_next   = ~sel_reg;
          phase_next = '0;
          tmo_next   = '0;
          sub_next   = '0;
          cm_next    = '0;
          state_next = bus.enable ? TRIG : IDLE;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (pub_timeout) begin
`ifdef TIMEOUT_HOLD_EN
      pub_dist = dist_w[sel_reg];
`else
      pub_dist = DIST_MAX;
`endif
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lane
    logic              sync1_reg, sync2_reg, echo_d_reg;
    logic              valid_reg, timeout_reg;
    logic [DIST_W-1:0] dist_reg;
    logic              own;

    assign own = publish && (sel_reg == 1'(gi));

    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        echo_d_reg  <= 1'b0;
        valid_reg   <= 1'b0;
        timeout_reg <= 1'b0;
        dist_reg    <= '0;
      end else begin
        sync1_reg  <= bus.echo_in[gi];
        sync2_reg  <= sync1_reg;
        echo_d_reg <= sync2_reg;
        valid_reg  <= own;
        if (own) begin
          dist_reg    <= pub_dist;
          timeout_reg <= pub_timeout;
        end
      end
    end

    assign echo_sync_w[gi] = sync2_reg;
    assign echo_prev_w[gi] = echo_d_reg;
    assign valid_w[gi]     = valid_reg;
    assign timeout_w[gi]   = timeout_reg;
    assign dist_w[gi]      = dist_reg;
  end

  assign bus.trig_out   = (state_reg == TRIG) ? (sel_reg ? 2'b10 : 2'b01) : 2'b00;
  assign bus.dist_p1    = dist_w[0];
  assign bus.dist_p2    = dist_w[1];
  assign bus.valid_p1   = valid_w[0];
  assign bus.valid_p2   = valid_w[1];
  assign bus.timeout_p1 = timeout_w[0];
  assign bus.timeout_p2 = timeout_w[1];
  assign bus.busy       = (state_reg != IDLE);
  assign bus.sel        = sel_reg;
endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Directed bench for ultrasonic_ping_scheduler with small timing parameters.
module tb_ultrasonic_ping_scheduler;
  localparam int DW = 6;
  localparam logic [DW-1:0] SAT = 6'd63;
`ifdef TIMEOUT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic resetn;

  ultrasonic_ping_scheduler_if #(.DIST_W(DW)) bus ();

  ultrasonic_ping_scheduler #(
    .TRIG_CYCLES(4),
    .CYCLES_PER_CM(3),
    .TIMEOUT_CYCLES(100),
    .HOLDOFF_CYCLES(10),
    .DIST_W(DW)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid2;
  logic [DW-1:0] prev_d1 = '0;
  logic [DW-1:0] prev_d2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each edge and checking invariants.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
      chk("trig_not_both", {31'd0, bus.trig_out == 2'b11}, 32'd0);
      chk("valid_not_both", {31'd0, bus.valid_p1 && bus.valid_p2}, 32'd0);
      if (resetn) begin
        chk("dist_p1_only_on_valid", {31'd0, (bus.dist_p1 != prev_d1) && !bus.valid_p1}, 32'd0);
        chk("dist_p2_only_on_valid", {31'd0, (bus.dist_p2 != prev_d2) && !bus.valid_p2}, 32'd0);
      end
      prev_d1 = bus.dist_p1;
      prev_d2 = bus.dist_p2;
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.enable = 1'b0;
    bus.echo_in = 2'b00;
    step(3);
    chk("rst_trig", bus.trig_out, 2'b00);
    chk("rst_dist_p1", bus.dist_p1, 0);
    chk("rst_dist_p2", bus.dist_p2, 0);
    chk("rst_valid", {bus.valid_p2, bus.valid_p1}, 2'b00);
    chk("rst_timeout", {bus.timeout_p2, bus.timeout_p1}, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sel", bus.sel, 1'b0);

    // Trigger for player 1 lasts exactly 4 clocks
    resetn = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("trig_p1_high", bus.trig_out, 2'b01);
    end
    chk("busy_in_trig", bus.busy, 1'b1);
    step(1);
    chk("trig_p1_fall", bus.trig_out, 2'b00);

    // 30-clock echo on player 1 -> 10 cm, strobe 3 clocks after pad fall
    bus.echo_in[0] = 1'b1;
    step(30);
    bus.echo_in[0] = 1'b0;
    step(2);
    chk("p1_valid_early", bus.valid_p1, 1'b0);
    step(1);
    chk("p1_valid", bus.valid_p1, 1'b1);
    chk("p1_dist10", bus.dist_p1, 10);
    chk("p1_timeout0", bus.timeout_p1, 1'b0);
    chk("p2_untouched", bus.dist_p2, 0);
    step(1);
    chk("p1_valid_one_cycle", bus.valid_p1, 1'b0);
    chk("p1_dist_held", bus.dist_p1, 10);
    step(8);
    chk("holdoff_sel0", bus.sel, 1'b0);
    chk("holdoff_trig", bus.trig_out, 2'b00);
    step(1);
    chk("sel_toggled", bus.sel, 1'b1);
    chk("trig_p2_high", bus.trig_out, 2'b10);
    step(3);
    chk("trig_p2_last", bus.trig_out, 2'b10);
    step(1);
    chk("trig_p2_fall", bus.trig_out, 2'b00);

    // No echo on player 2 -> timeout 100 clocks after trigger fall
    step(99);
    chk("p2_tmo_early", bus.valid_p2, 1'b0);
    step(1);
    chk("p2_tmo_valid", bus.valid_p2, 1'b1);
    chk("p2_tmo_dist", bus.dist_p2, HOLD ? 6'd0 : SAT);
    chk("p2_tmo_flag", bus.timeout_p2, 1'b1);
    chk("p1_kept", bus.dist_p1, 10);
    step(10);
    chk("back_to_p1", bus.trig_out, 2'b01);
    step(4);

    // Player 1: 9-clock echo -> 3 cm; echo[1] rises meanwhile and must be ignored
    bus.echo_in = 2'b11;
    step(9);
    bus.echo_in[0] = 1'b0;
    step(3);
    chk("p1_valid_b", bus.valid_p1, 1'b1);
    chk("p1_dist3", bus.dist_p1, 3);
    chk("p2_ignored", bus.valid_p2, 1'b0);
    step(10);
    chk("p2_turn", bus.trig_out, 2'b10);
    step(4);

    // Echo[1] already high entering WAIT_RISE, then falls: no rise, so timeout
    step(20);
    bus.echo_in[1] = 1'b0;
    n_valid2 = 0;
    for (int i = 0; i < 79; i++) begin
      step(1);
      if (bus.valid_p2) n_valid2++;
    end
    chk("p2_stale_high_ignored", n_valid2, 0);
    step(1);
    chk("p2_tmo2_valid", bus.valid_p2, 1'b1);
    chk("p2_tmo2_flag", bus.timeout_p2, 1'b1);
    chk("p2_tmo2_dist", bus.dist_p2, HOLD ? 6'd0 : SAT);
    step(10);
    chk("p1_turn_c", bus.trig_out, 2'b01);
    step(4);

    // Player 1 no echo: timeout sets the sticky flag
    step(99);
    chk("p1_tmo_early", bus.valid_p1, 1'b0);
    step(1);
    chk("p1_tmo_valid", bus.valid_p1, 1'b1);
    chk("p1_tmo_dist", bus.dist_p1, HOLD ? 6'd3 : SAT);
    chk("p1_tmo_flag", bus.timeout_p1, 1'b1);
    step(10);
    chk("p2_turn_d", bus.sel, 1'b1);
    step(4);

    // Player 2 fresh rise held past the timeout
    bus.echo_in[1] = 1'b1;
    step(99);
    chk("p2_long_early", bus.valid_p2, 1'b0);
    step(1);
    chk("p2_long_valid", bus.valid_p2, 1'b1);
    chk("p2_long_dist", bus.dist_p2, HOLD ? 6'd0 : SAT);
    chk("p2_long_flag", bus.timeout_p2, 1'b1);
    step(10);
    chk("p1_turn_e", bus.trig_out, 2'b01);
    step(4);

    // Enable dropped during MEASURE: result published, then IDLE with sel toggled
    bus.echo_in[0] = 1'b1;
    step(4);
    bus.enable = 1'b0;
    step(2);
    bus.echo_in = 2'b00;
    step(2);
    chk("p1_sticky_tmo", bus.timeout_p1, 1'b1);
    step(1);
    chk("p1_dis_valid", bus.valid_p1, 1'b1);
    chk("p1_dist2", bus.dist_p1, 2);
    chk("p1_tmo_cleared", bus.timeout_p1, 1'b0);
    step(9);
    chk("holdoff_busy", bus.busy, 1'b1);
    step(1);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_sel", bus.sel, 1'b1);
    step(20);
    chk("idle_stays", {bus.busy, bus.trig_out}, 3'b000);

    // Reset in the middle of TRIG
    bus.enable = 1'b1;
    step(1);
    chk("retrig_p2", bus.trig_out, 2'b10);
    step(1);
    resetn = 1'b0;
    step(1);
    chk("rst2_trig", bus.trig_out, 2'b00);
    chk("rst2_dist_p1", bus.dist_p1, 0);
    chk("rst2_dist_p2", bus.dist_p2, 0);
    chk("rst2_timeout", {bus.timeout_p2, bus.timeout_p1}, 2'b00);
    chk("rst2_sel", bus.sel, 1'b0);
    chk("rst2_busy", bus.busy, 1'b0);
    bus.enable = 1'b0;
    resetn = 1'b1;
    step(5);
    chk("post_rst_idle", {bus.busy, bus.trig_out, bus.valid_p2, bus.valid_p1}, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
